// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the irom port, buffers words for decode.
// Define IFETCH_DBG_PORT_EN to share the ROM port with a debug reader through a fair arbiter.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_pc_o,
    input  logic [31:0] rom_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
`ifdef IFETCH_DBG_PORT_EN
    ,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_addr_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    fetch_entry_t     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc;

    logic pop;
    logic fetch_want;
    logic fetch_gnt;
    logic unused_addr_bits;

    assign inst_valid_o = (count != '0);
    assign inst_o       = fifo_mem[rd_ptr].inst;
    assign inst_pc_o    = fifo_mem[rd_ptr].pc;

    // A full FIFO that pops this cycle may still fetch into the freed slot.
    assign pop        = inst_valid_o & inst_ready_i & ~redirect_i;
    assign fetch_want = ~redirect_i & ((count < CNT_W'(FIFO_DEPTH)) | pop);

`ifdef IFETCH_DBG_PORT_EN
    logic last_dbg;
    logic dbg_gnt;

    // Debug yields after a win whenever fetch is waiting, so neither side starves.
    assign dbg_gnt   = dbg_req_i & ~(last_dbg & fetch_want);
    assign fetch_gnt = fetch_want & ~dbg_gnt;
    assign rom_pc_o  = dbg_gnt ? {dbg_addr_i[31:2], 2'b00} : pc;
    assign unused_addr_bits = ^{redirect_pc_i[1:0], dbg_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg    <= 1'b0;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= 32'h0;
        end else begin
            last_dbg  <= dbg_gnt;
            dbg_ack_o <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata_o <= rom_inst_i;
            end
        end
    end
`else
    assign fetch_gnt = fetch_want;
    assign rom_pc_o  = pc;
    assign unused_addr_bits = ^redirect_pc_i[1:0];
`endif

    // PC and instruction buffer; redirect flushes and re-steers ahead of any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (redirect_i) begin
            pc     <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch_gnt) begin
                fifo_mem[wr_ptr] <= '{pc: pc, inst: rom_inst_i};
                wr_ptr           <= wr_ptr + PTR_W'(1);
                pc               <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(fetch_gnt) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a queue-level model predicts each cycle's outputs,
// a monitor process pops and compares them; directed scenarios followed by random traffic.
module tb_ifetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_pc_o;
    logic [31:0] rom_inst_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
`ifdef IFETCH_DBG_PORT_EN
    logic        dbg_req_i = 1'b0;
    logic [31:0] dbg_addr_i = 32'h0;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
`endif

    ifetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_pc_o      (rom_pc_o),
        .rom_inst_i    (rom_inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
`ifdef IFETCH_DBG_PORT_EN
        ,
        .dbg_req_i     (dbg_req_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_ack_o     (dbg_ack_o),
        .dbg_rdata_o   (dbg_rdata_o)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents: low half is the word index, high half a scrambled copy.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [15:0] idx;
        idx = {2'b00, a[15:2]};
        return {idx ^ 16'hBEEF, idx};
    endfunction

    assign rom_inst_i = rom_word(rom_pc_o);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        valid;
        logic        chk_head;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ack;
        logic [31:0] rdata;
    } exp_t;

    ent_t        m_q[$];
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_rdata;
    logic        m_last_dbg;
    logic        m_ack;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.valid    = (m_q.size() != 0);
        e.chk_head = e.valid;
        e.pc       = e.valid ? m_q[0].pc : 32'h0;
        e.inst     = e.valid ? m_q[0].inst : 32'h0;
        e.ack      = m_ack;
        e.rdata    = m_rdata;
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc       = RPC;
        m_last_dbg = 1'b0;
        m_ack      = 1'b0;
        m_rdata    = 32'h0;
    endtask

    // Reset state expects head outputs at zero as well as valid low.
    task automatic push_reset_exp();
        exp_t e;
        e = snapshot();
        e.chk_head = 1'b1;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus at a falling edge and predict the state after the next rising edge.
    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy,
                         input logic dreq, input logic [31:0] daddr);
        logic        valid, pop, want, gnt, fgnt;
        logic [31:0] exp_rom;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
`ifdef IFETCH_DBG_PORT_EN
        dbg_req_i  = dreq;
        dbg_addr_i = daddr;
        gnt = dreq & ~(m_last_dbg & ((m_q.size() < DEPTH) | (m_q.size() != 0 && rdy)) & ~redir);
`else
        gnt = 1'b0;
`endif
        valid   = (m_q.size() != 0);
        pop     = valid & rdy & ~redir;
        want    = ~redir & ((m_q.size() < DEPTH) | pop);
        fgnt    = want & ~gnt;
        exp_rom = gnt ? {daddr[31:2], 2'b00} : m_pc;
        if (redir) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_q.pop_front());
            if (fgnt) begin
                m_q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_last_dbg = gnt;
        m_ack      = gnt;
        if (gnt) m_rdata = rom_word(exp_rom);
        exp_q.push_back(snapshot());
        #1;
        chk("rom_pc", rom_pc_o, exp_rom);
        @(negedge clk);
    endtask

    task automatic run_ready(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rdy, 1'b0, 32'h0);
    endtask

    // Monitor: compare registered outputs against the oldest prediction each cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("inst_valid", 32'(inst_valid_o), 32'(mon_e.valid));
                if (mon_e.chk_head) begin
                    chk("inst_pc", inst_pc_o, mon_e.pc);
                    chk("inst", inst_o, mon_e.inst);
                end
`ifdef IFETCH_DBG_PORT_EN
                chk("dbg_ack", 32'(dbg_ack_o), 32'(mon_e.ack));
                chk("dbg_rdata", dbg_rdata_o, mon_e.rdata);
`endif
                if (inst_valid_o && inst_ready_i && !redirect_i) begin
                    chk("rom_word_of_pc", inst_o, rom_word(inst_pc_o));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_reset_exp();

        // Streaming from reset, one word per cycle.
        run_ready(8, 1'b1);
        // Stall fills the buffer, then drains back to back.
        run_ready(5, 1'b0);
        run_ready(5, 1'b1);
        // Redirect to an unaligned target with the buffer full.
        run_ready(3, 1'b0);
        drive(1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0);
        run_ready(5, 1'b1);
`ifdef IFETCH_DBG_PORT_EN
        // Debug contends with streaming fetch, then with a full, stalled buffer.
        for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0020);
        run_ready(3, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0020);
        run_ready(3, 1'b1);
`endif
        // PC wraps from the top of the address space.
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        run_ready(5, 1'b1);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), $urandom);
        end
        run_ready(3, 1'b1);
        #2;
        mon_en = 1'b0;

        // Asynchronous reset mid-stream clears outputs without waiting for a clock.
        run_ready(0, 1'b1);
        @(negedge clk);
        inst_ready_i = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_inst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_rom_pc", rom_pc_o, RPC);
`ifdef IFETCH_DBG_PORT_EN
        chk("rst_dbg_ack", 32'(dbg_ack_o), 32'h0);
        chk("rst_dbg_rdata", dbg_rdata_o, 32'h0);
`endif
        exp_q.delete();
        @(negedge clk);
        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_reset_exp();
        run_ready(5, 1'b1);
        #2;
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
